// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// with sign fix-up, divide-by-zero and signed-overflow short cuts.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] rem_p0, quo_p0, dvs_p0;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             accept, div_zero, ovf;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] s;
    s = v;
    return (sgn && s < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept   = start && (state != CALC);
  assign div_zero = (divisor == '0);
  assign ovf      = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  // Trial subtraction: a borrow out means the shifted partial remainder is kept.
  assign trial  = {rem_p0, quo_p0[WIDTH-1]} - {1'b0, dvs_p0};
  assign rem_nx = trial[WIDTH] ? {rem_p0[WIDTH-2:0], quo_p0[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_nx = {quo_p0[WIDTH-2:0], ~trial[WIDTH]};

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (div_zero || ovf) begin
              state     <= DONE;
              quotient  <= div_zero ? '1 : dividend;
              remainder <= div_zero ? dividend : '0;
            end else begin
              state <= CALC;
              cnt   <= '0;
              neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r <= is_signed && dividend[WIDTH-1];
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(WIDTH-1)) begin
            state     <= DONE;
            quotient  <= apply_sign(quo_nx, neg_q);
            remainder <= apply_sign(rem_nx, neg_r);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath working registers: loaded on acceptance, shifted every CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_p0 <= '0;
      quo_p0 <= magnitude(dividend, is_signed);
      dvs_p0 <= magnitude(divisor, is_signed);
    end else if (state == CALC) begin
      rem_p0 <= rem_nx;
      quo_p0 <= quo_nx;
    end
  end

endmodule
